// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory constants: access types, flat BRAM bases, register offsets,
// requester IDs and the response tag carried through the BRAM latency pipe.
package chip8_pkg;

   localparam int PROC_MEM_TYPE_RAM   = 0;
   localparam int PROC_MEM_TYPE_REG   = 1;
   localparam int PROC_MEM_TYPE_STACK = 2;
   localparam int PROC_MEM_TYPE_COUNT = 3;
   localparam int TYPE_W              = $clog2(PROC_MEM_TYPE_COUNT);

   localparam logic [15:0] REG_BASE   = 16'h1000;
   localparam logic [15:0] STACK_BASE = 16'h1020;

   localparam int REG_IH  = 16;
   localparam int REG_IL  = 17;
   localparam int REG_PCH = 18;
   localparam int REG_PCL = 19;
   localparam int REG_SP  = 20;
   localparam int REG_DT  = 21;
   localparam int REG_ST  = 22;

   // Highest legal offsets inside the register and stack windows.
   localparam int REG_LAST   = REG_ST;
   localparam int STACK_LAST = 31;

   // Interpreter area; only the ROM loader may write below this address.
   localparam logic [11:0] RAM_PROTECT_END = 12'h200;

   localparam int REQ_PROC   = 0;
   localparam int REQ_DRAW   = 1;
   localparam int REQ_LOADER = 2;

   // Wide enough for the largest supported requester count (4).
   localparam int REQ_ID_W = 2;

   typedef struct packed {
      logic                is_read;
      logic [REQ_ID_W-1:0] id;
      logic                err;
   } rsp_tag_t;

   // Typed 12-bit address to flat BRAM address; unused encodings fall back to RAM.
   function automatic logic [15:0] map_addr(input logic [TYPE_W-1:0] typ,
                                            input logic [11:0]        addr);
      case (typ)
         TYPE_W'(PROC_MEM_TYPE_REG):   map_addr = REG_BASE + {11'd0, addr[4:0]};
         TYPE_W'(PROC_MEM_TYPE_STACK): map_addr = STACK_BASE + {11'd0, addr[4:0]};
         default:                      map_addr = {4'd0, addr};
      endcase
   endfunction

endpackage

// File: rtl/chip8_rr_arbiter.sv
// Round-robin single-grant arbiter. Search starts one past the last accepted
// requester; the pointer moves only when a grant (and hence an accept) occurs.
module chip8_rr_arbiter #(
   parameter int N    = 3,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [N-1:0]    valid,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            grant_any
);

   logic [ID_W-1:0] last_q;
   int              idx;

   // Grant is only raised toward a valid requester, so grant[i] alone means accept.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!rst_in) begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!grant_any && valid[idx]) begin
               grant[idx] = 1'b1;
               grant_id   = ID_W'(idx);
               grant_any  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_q <= ID_W'(N - 1);
      end else if (grant_any) begin
         last_q <= grant_id;
      end
   end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares the CHIP-8 state BRAM port among NUM_REQ requesters with round-robin
// grant, typed address mapping and in-order read-response routing.
// Optional access checking: define CHIP8_MEM_ARB_CHECK_EN.
module chip8_mem_arbiter
   import chip8_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int BRAM_LATENCY = 2,
   parameter int BRAM_ADDR_W  = 13
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   input  logic [NUM_REQ*12-1:0]     req_addr_in,
   input  logic [NUM_REQ-1:0]        req_we_in,
   input  logic [NUM_REQ*8-1:0]      req_data_in,
   input  logic [NUM_REQ*TYPE_W-1:0] req_type_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   output logic [NUM_REQ-1:0]        rsp_valid_out,
   output logic [7:0]                rsp_data_out,
   output logic [BRAM_ADDR_W-1:0]    bram_addr_out,
   output logic                      bram_we_out,
   output logic [7:0]                bram_din_out,
   input  logic [7:0]                bram_dout_in,
   output logic                      error_out
);

   localparam int ID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("chip8_mem_arbiter: NUM_REQ must be 2..4");
   end
   if (BRAM_LATENCY < 1) begin : g_bad_latency
      $error("chip8_mem_arbiter: BRAM_LATENCY must be at least 1");
   end

   // Handshake: a transfer happens when req_valid_in[i] && req_ready_out[i].
   // ready is a combinational function of valid (the arbiter grant); requesters
   // hold addr/we/data/type stable while valid && !ready and never gate valid on ready.
   logic [ID_W-1:0]        gnt_id;
   logic                   accept;

   chip8_rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .valid     (req_valid_in),
      .grant     (req_ready_out),
      .grant_id  (gnt_id),
      .grant_any (accept)
   );

   logic [11:0]            sel_addr;
   logic                   sel_we;
   logic [7:0]             sel_data;
   logic [TYPE_W-1:0]      sel_type;
   logic [BRAM_ADDR_W-1:0] mapped_addr;
   logic                   illegal;

   always_comb begin
      sel_addr    = req_addr_in[int'(gnt_id)*12 +: 12];
      sel_we      = req_we_in[gnt_id];
      sel_data    = req_data_in[int'(gnt_id)*8 +: 8];
      sel_type    = req_type_in[int'(gnt_id)*TYPE_W +: TYPE_W];
      mapped_addr = BRAM_ADDR_W'(map_addr(sel_type, sel_addr));
   end

`ifdef CHIP8_MEM_ARB_CHECK_EN
   logic error_q;

   always_comb begin
      illegal = 1'b0;
      case (sel_type)
         TYPE_W'(PROC_MEM_TYPE_RAM):
            illegal = sel_we && (sel_addr < RAM_PROTECT_END) &&
                      (int'(gnt_id) != REQ_LOADER);
         TYPE_W'(PROC_MEM_TYPE_REG):   illegal = sel_addr > 12'(REG_LAST);
         TYPE_W'(PROC_MEM_TYPE_STACK): illegal = sel_addr > 12'(STACK_LAST);
         default:                      illegal = 1'b1;
      endcase
   end

   // Sticky until reset so software can poll it after the fact.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         error_q <= 1'b0;
      end else if (accept && illegal) begin
         error_q <= 1'b1;
      end
   end

   assign error_out = error_q;
`else
   assign illegal   = 1'b0;
   assign error_out = 1'b0;
`endif

   logic [BRAM_ADDR_W-1:0] addr_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q <= '0;
      end else if (accept) begin
         addr_q <= mapped_addr;
      end
   end

   // Address is live in the accept cycle and parked on the last value otherwise.
   always_comb begin
      bram_addr_out = accept ? mapped_addr : addr_q;
      bram_we_out   = accept && sel_we && !illegal;
      bram_din_out  = accept ? sel_data : 8'h00;
   end

   rsp_tag_t new_tag;
   rsp_tag_t out_tag;
   rsp_tag_t tag_q [BRAM_LATENCY];

   always_comb begin
      new_tag         = '0;
      new_tag.is_read = accept && !sel_we;
      new_tag.id      = REQ_ID_W'(gnt_id);
      new_tag.err     = accept && illegal;
   end

   // Tag pipe mirrors the BRAM read latency, so responses leave in accept order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < BRAM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= new_tag;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign out_tag = tag_q[BRAM_LATENCY-1];

   always_comb begin
      rsp_valid_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_out[i] = !rst_in && out_tag.is_read &&
                            (out_tag.id == REQ_ID_W'(i));
      end
      rsp_data_out = out_tag.err ? 8'h00 : bram_dout_in;
   end

endmodule
